// File: rtl/dvi_in_channel_align.sv
// Inter-channel deskew for the three DVI input channels: measures skew on the
// blanking-to-active edge and re-times each channel through a tap-selected delay line.

module dvi_in_channel_align_lane #(
  parameter int MAX_SKEW = 3,
  parameter int DW       = 2
) (
  input  logic          pclk1x,
  input  logic          rst_ps,
  input  logic [10:0]   sym_in,   // {de, ctrl[1:0], data[7:0]}
  input  logic [DW-1:0] delay,
  output logic          tap_de,
  output logic [9:0]    sym_q     // registered {ctrl, data} from the selected tap
);
  logic [10:0] sr [1:MAX_SKEW];
  logic [10:0] tap;

  always_ff @(posedge pclk1x) begin
    sr[1] <= sym_in;
    for (int k = 2; k <= MAX_SKEW; k++) sr[k] <= sr[k-1];
  end

  // tap 0 is the live input, tap k is k cycles old
  always_comb begin
    tap = sym_in;
    for (int k = 1; k <= MAX_SKEW; k++)
      if (delay == DW'(k)) tap = sr[k];
  end

  assign tap_de = tap[10];

  always_ff @(posedge pclk1x) begin
    if (rst_ps) sym_q <= '0;
    else        sym_q <= tap[9:0];
  end
endmodule

module dvi_in_channel_align #(
  parameter  int MAX_SKEW = 3,
  localparam int DW       = $clog2(MAX_SKEW+1)
) (
  input  logic          pclk1x,
  input  logic          rst_ps,
  input  logic [2:0]    in_valid,
  input  logic [2:0]    in_de,
  input  logic [23:0]   in_data,
  input  logic [5:0]    in_ctrl,
  output logic [23:0]   out_data,
  output logic [5:0]    out_ctrl,
  output logic          out_de,
  output logic          aligned,
  output logic [3*DW-1:0] delay_o,
  output logic [7:0]    fail_count
);
  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_WINDOW = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]            state, state_n;
  logic [2:0]            de_prev, rise, rec, rec_n;
  logic [2:0]            ade, ade_prev, arise;
  logic [2:0][DW-1:0]    t_q, t_n, delay_q, delay_n;
  logic [DW-1:0]         cnt, cnt_n, cnt_inc, tmax;
  logic                  fail;
  logic [2:0][9:0]       sym_q;

  genvar c;
  generate
    for (c = 0; c < 3; c++) begin : g_lane
      dvi_in_channel_align_lane #(.MAX_SKEW(MAX_SKEW), .DW(DW)) u_lane (
        .pclk1x (pclk1x),
        .rst_ps (rst_ps),
        .sym_in ({in_de[c], in_ctrl[2*c+:2], in_data[8*c+:8]}),
        .delay  (delay_q[c]),
        .tap_de (ade[c]),
        .sym_q  (sym_q[c])
      );
      assign out_data[8*c+:8] = sym_q[c][7:0];
      assign out_ctrl[2*c+:2] = sym_q[c][9:8];
    end
  endgenerate

  assign rise    = in_de & ~de_prev & in_valid;
  assign arise   = ade & ~ade_prev;
  assign cnt_inc = cnt + DW'(1);
  assign aligned = (state == S_LOCKED);
  assign delay_o = delay_q;

  always_comb begin
    state_n = state;
    rec_n   = rec;
    t_n     = t_q;
    cnt_n   = cnt;
    delay_n = delay_q;
    fail    = 1'b0;
    tmax    = '0;
    case (state)
      S_SEARCH: begin
        if (|rise) begin
          state_n = S_WINDOW;
          cnt_n   = '0;
          rec_n   = rise;
          t_n     = '0;
        end
      end
      S_WINDOW: begin
        cnt_n = cnt_inc;
        for (int i = 0; i < 3; i++)
          if (rise[i] && !rec[i]) begin
            rec_n[i] = 1'b1;
            t_n[i]   = cnt_inc;
          end
        for (int i = 0; i < 3; i++)
          if (t_n[i] > tmax) tmax = t_n[i];
        // an invalid symbol outranks a completed measurement
        if (!(&in_valid)) begin
          fail = 1'b1;
        end else if (&rec_n) begin
          for (int i = 0; i < 3; i++) delay_n[i] = tmax - t_n[i];
          state_n = S_LOCKED;
        end else if (cnt_inc == DW'(MAX_SKEW)) begin
          fail = 1'b1;
        end
        if (fail) state_n = S_SEARCH;
      end
      S_LOCKED: begin
        if ((|arise) && !(&arise)) begin
          fail    = 1'b1;
          state_n = S_SEARCH;
        end
      end
      default: state_n = S_SEARCH;
    endcase
  end

  always_ff @(posedge pclk1x) begin
    if (rst_ps) begin
      state      <= S_SEARCH;
      cnt        <= '0;
      rec        <= '0;
      t_q        <= '0;
      delay_q    <= '0;
      de_prev    <= '0;
      ade_prev   <= '0;
      out_de     <= 1'b0;
      fail_count <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rec      <= rec_n;
      t_q      <= t_n;
      delay_q  <= delay_n;
      de_prev  <= in_de;
      ade_prev <= ade;
      out_de   <= ade[0];
      if (fail && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_dvi_in_channel_align.sv
// Bench for dvi_in_channel_align: scoreboarded aligned pixels plus lock/fail status checks.

module tb_dvi_in_channel_align;
  localparam int DW = 2;

  logic          pclk1x = 1'b0;
  logic          rst_ps;
  logic [2:0]    in_valid, in_de;
  logic [23:0]   in_data;
  logic [5:0]    in_ctrl;
  logic [23:0]   out_data;
  logic [5:0]    out_ctrl;
  logic          out_de, aligned;
  logic [3*DW-1:0] delay_o;
  logic [7:0]    fail_count;

  dvi_in_channel_align #(.MAX_SKEW(3)) dut (
    .pclk1x(pclk1x), .rst_ps(rst_ps), .in_valid(in_valid), .in_de(in_de),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_de(out_de), .aligned(aligned), .delay_o(delay_o), .fail_count(fail_count)
  );

  always #5 pclk1x = ~pclk1x;

  int cyc = 0;
  always @(posedge pclk1x) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  typedef struct { int due; logic [29:0] word; } sb_t;
  sb_t sb[$];
  sb_t e_mon;
  logic [7:0] base [3] = '{8'hA5, 8'h5A, 8'h3C};

  function automatic logic [7:0] pix(input int ch, input int n);
    return base[ch] + 8'(n);
  endfunction

  always @(negedge pclk1x)
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e_mon = sb.pop_front();
      chk("pix", {2'b0, out_ctrl, out_data}, {2'b0, e_mon.word});
    end

  task automatic step();
    @(posedge pclk1x);
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      in_de = '0; in_valid = 3'b111; in_data = '0; in_ctrl = '0;
      step();
    end
  endtask

  // one cycle of a frame where channel c goes active at cycle r_c; pixels of the
  // latest channel from minpush on are expected aligned one cycle later
  task automatic act(input int i, input int r0, input int r1, input int r2,
                     input int minpush, input logic [2:0] vld);
    int r[3];
    int rmax;
    logic [7:0] p;
    logic [29:0] w;
    r = '{r0, r1, r2};
    rmax = r0;
    if (r1 > rmax) rmax = r1;
    if (r2 > rmax) rmax = r2;
    for (int ch = 0; ch < 3; ch++) begin
      if (i >= r[ch]) begin
        p = pix(ch, i - r[ch]);
        in_de[ch] = 1'b1; in_data[8*ch+:8] = p; in_ctrl[2*ch+:2] = p[1:0];
      end else begin
        in_de[ch] = 1'b0; in_data[8*ch+:8] = '0; in_ctrl[2*ch+:2] = '0;
      end
    end
    in_valid = vld;
    if (minpush >= 0 && i - rmax >= minpush) begin
      for (int ch = 0; ch < 3; ch++) begin
        p = pix(ch, i - rmax);
        w[8*ch+:8] = p; w[24+2*ch+:2] = p[1:0];
      end
      sb.push_back('{cyc + 1, w});
    end
    step();
  endtask

  task automatic do_reset();
    rst_ps = 1'b1;
    blank(2);
    rst_ps = 1'b0;
  endtask

  initial begin
    rst_ps = 1'b1;
    blank(3);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ctrl", 32'(out_ctrl), 0);
    chk("rst_de", 32'(out_de), 0);
    chk("rst_aligned", 32'(aligned), 0);
    chk("rst_delay", 32'(delay_o), 0);
    chk("rst_fail", 32'(fail_count), 0);
    rst_ps = 1'b0;

    // zero skew
    blank(3);
    for (int i = 0; i < 8; i++) begin
      act(i, 0, 0, 0, 0, 3'b111);
      if (i == 0) chk("zero_lock_early", 32'(aligned), 0);
      if (i == 1) chk("zero_lock", 32'(aligned), 1);
    end
    chk("zero_delay", 32'(delay_o), 0);
    chk("zero_fail", 32'(fail_count), 0);

    // lock loss: ch1 late while locked at 0/0/0, its late edge opens a window that times out
    blank(3);
    for (int i = 0; i < 8; i++) begin
      act(i, 0, 1, 0, -1, 3'b111);
      if (i == 0) begin
        chk("loss_aligned", 32'(aligned), 0);
        chk("loss_fail", 32'(fail_count), 1);
      end
    end
    chk("loss_fail2", 32'(fail_count), 2);
    blank(3);
    for (int i = 0; i < 8; i++) act(i, 0, 1, 0, 1, 3'b111);
    chk("relock_delay", 32'(delay_o), 32'h11);
    chk("relock_aligned", 32'(aligned), 1);
    chk("relock_fail", 32'(fail_count), 2);
    blank(3);

    // skew 0/2/1
    do_reset();
    blank(2);
    for (int i = 0; i < 8; i++) begin
      act(i, 0, 2, 1, 1, 3'b111);
      if (i == 1) chk("skew_lock_early", 32'(aligned), 0);
      if (i == 2) chk("skew_lock", 32'(aligned), 1);
    end
    chk("skew_delay", 32'(delay_o), 32'h12);
    chk("skew_fail", 32'(fail_count), 0);
    blank(3);

    // excess skew: ch2 four cycles late
    do_reset();
    blank(2);
    for (int i = 0; i < 10; i++) begin
      act(i, 0, 0, 4, -1, 3'b111);
      if (i == 3) begin
        chk("excess_fail", 32'(fail_count), 1);
        chk("excess_aligned", 32'(aligned), 0);
      end
    end
    chk("excess_fail2", 32'(fail_count), 2);
    chk("excess_delay", 32'(delay_o), 0);
    blank(3);
    for (int i = 0; i < 8; i++) act(i, 0, 0, 1, 1, 3'b111);
    chk("excess_relock", 32'(aligned), 1);
    chk("excess_redelay", 32'(delay_o), 32'h05);
    blank(3);

    // invalid symbol in window beats completion; saturation
    do_reset();
    blank(2);
    for (int k = 0; k < 300; k++) begin
      blank(1);
      act(0, 0, 0, 0, -1, 3'b111);
      act(1, 0, 0, 0, -1, 3'b101);
      if (k == 0) begin
        chk("inv_fail", 32'(fail_count), 1);
        chk("inv_aligned", 32'(aligned), 0);
      end
      if (k == 254) chk("inv_fail255", 32'(fail_count), 255);
    end
    chk("sat_fail", 32'(fail_count), 255);
    chk("sat_aligned", 32'(aligned), 0);
    chk("sat_delay", 32'(delay_o), 0);

    // reset mid-window at cnt=1
    do_reset();
    blank(3);
    act(0, 0, 1, 2, -1, 3'b111);
    act(1, 0, 1, 2, -1, 3'b111);
    rst_ps = 1'b1;
    act(2, 0, 1, 2, -1, 3'b111);
    rst_ps = 1'b0;
    chk("mid_data", 32'(out_data), 0);
    chk("mid_ctrl", 32'(out_ctrl), 0);
    chk("mid_de", 32'(out_de), 0);
    chk("mid_aligned", 32'(aligned), 0);
    chk("mid_fail", 32'(fail_count), 0);
    blank(4);
    chk("mid_fail_after", 32'(fail_count), 0);
    for (int i = 0; i < 8; i++) begin
      act(i, 0, 0, 0, 0, 3'b111);
      if (i == 1) chk("mid_relock", 32'(aligned), 1);
    end
    chk("mid_delay", 32'(delay_o), 0);

    blank(4);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
